hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard detection for the five-stage MIPS pipeline, replacing pure comparator logic with a per-register pending-write scoreboard.
- Each destination register has a countdown of remaining stall cycles, so the block handles the following with configurable latencies:
  - load-use stalls
  - ALU-to-branch stalls
  - load-to-branch stalls
  - any deeper future memory or branch timing
- Sits beside the ID stage. Drives PC write-enable, IF/ID write-enable and the ID/EX bubble select.

Parameters:
- REG_W, 5: register index width; NUM_REGS = 2**REG_W.
- ALU_BR_STALL, 1: stall cycles an ALU result imposes on a branch consumer in ID.
- LOAD_BR_STALL, 2: stall cycles a load result imposes on a branch consumer in ID.
- LOAD_USE_STALL, 1: stall cycles a load result imposes on a non-branch consumer. Must be ≤ LOAD_BR_STALL.
- CNT_W, 2: counter width. Must hold max(ALU_BR_STALL, LOAD_BR_STALL).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_flush  in  1  ID instruction is being squashed this cycle
- id_rs  in  REG_W  source register rs
- id_rt  in  REG_W  source register rt
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_is_branch  in  1  instruction compares operands in ID (beq/bne)
- id_reg_write  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- id_dest  in  REG_W  destination register (rd or rt, already muxed)
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- stall  out  1  force ID/EX control to bubble
- busy_vec  out  NUM_REGS  bit r set when cnt[r] != 0 (debug/verif)

Behaviour:
- State per register r: cnt[r] (CNT_W bits) and ld[r] (1 bit). Reset clears all to 0 asynchronously.
- Register 0 never hazards: cnt[0] and ld[0] are held at 0.
- Source hazard, for src in {rs, rt} with its use bit set and src != 0:
  - branch consumer: hazard if cnt[src] != 0.
  - non-branch consumer: hazard if ld[src] and cnt[src] > (LOAD_BR_STALL - LOAD_USE_STALL).
- Combinational outputs:
  - stall = id_valid & ~id_flush & (hazard on rs | hazard on rt).
  - pc_write = if_id_write = ~stall.
- Outputs after reset: pc_write=1, if_id_write=1, stall=0, busy_vec=0.
- Issue: issue = id_valid & ~id_flush & ~stall & id_reg_write & (id_dest != 0). On issue, at the clock edge:
  - cnt[id_dest] <= id_is_load ? LOAD_BR_STALL : ALU_BR_STALL
  - ld[id_dest] <= id_is_load
- Ageing: every other r with cnt[r] != 0 decrements by 1 each cycle, whether or not a stall is active (bubbles keep the downstream stages moving).
- When cnt[r] reaches 0, ld[r] clears in the same edge.
- Simultaneous events:
  - Issue to a register already counting overwrites it; issue wins over decrement (newest writer).
  - Self-dependence (e.g. add $1,$1,$2) is evaluated against the old cnt before the issue update.
- A zero-latency parameter (e.g. ALU_BR_STALL=0) yields no scoreboard entry, so no stall.
- id_flush suppresses both stall and issue for that cycle. Existing counters still age.
- rst_n asserted mid-stall clears all state immediately; stall drops to 0 asynchronously.
- No arithmetic wrap: counters only load or decrement toward 0 and saturate at 0.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- When defined: adds output stall_cycles (32 bits), an event counter:
  - increments on every clock where stall=1
  - saturates at 0xFFFFFFFF
  - resets to 0 on rst_n
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw $2 issues, then and $4,$2,$5 (non-branch) in ID next cycle -> stall=1 for exactly 1 cycle, then pc_write=1. busy_vec[2] is 1 for 2 cycles.
- ALU-branch: add $1,$2,$3 then beq $1,$2 -> stall=1 for exactly 1 cycle. Non-branch consumer of $1 -> no stall.
- Load-branch: lw $1 then beq $1,$4 -> stall=1 for 2 consecutive cycles, then released. Using $0 as dest or source never stalls.
- Overwrite: lw $3 then, the next cycle, add $3 (no read of $3) then beq $3 -> ld[3]=0 and cnt reloaded to 1, giving a 1-cycle stall, not 2.
- Flush/reset: id_flush=1 with hazard present -> stall=0 and no issue. Assert rst_n=0 during the 2-cycle load-branch stall -> stall=0 immediately, busy_vec=0.
- With HAZARD_STALL_CNT_EN: the sequence above yields stall_cycles=5 after the four stalling scenarios (1+1+2+1).

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write scoreboard driving ID-stage stalls.
//
// Sits beside the ID stage of a five-stage MIPS pipeline. Every destination
// register carries a countdown of the cycles its result is still unavailable
// to a consumer in ID, plus a flag marking the pending writer as a load.
//
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   id_valid/id_flush ID holds a real instruction / it is squashed this cycle
//   id_rs, id_rt      source registers, qualified by id_use_rs / id_use_rt
//   id_is_branch      operands are compared in ID (beq/bne)
//   id_reg_write      instruction writes id_dest
//   id_is_load        instruction is a load
//   id_dest           destination register
//   pc_write          PC enable
//   if_id_write       IF/ID enable
//   stall             force ID/EX control to bubble
//   busy_vec          bit r set while register r has a pending countdown
//   stall_cycles      saturating count of stalled cycles (HAZARD_STALL_CNT_EN only)
//
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cycles counter.
module hazard_scoreboard #(
    parameter int REG_W          = 5,
    parameter int ALU_BR_STALL   = 1,
    parameter int LOAD_BR_STALL  = 2,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_flush,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_is_branch,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic [REG_W-1:0]      id_dest,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  stall,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic [2**REG_W-1:0]   busy_vec
);
    localparam int NUM_REGS = 2**REG_W;
    localparam logic [CNT_W-1:0] ALU_L  = CNT_W'(ALU_BR_STALL);
    localparam logic [CNT_W-1:0] LD_L   = CNT_W'(LOAD_BR_STALL);
    // A non-branch consumer of a load only waits while more than this many
    // branch-stall cycles remain, since it needs the value one stage later.
    localparam logic [CNT_W-1:0] USE_TH = CNT_W'(LOAD_BR_STALL - LOAD_USE_STALL);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ld;
    logic                hz_rs;
    logic                hz_rt;
    logic                issue;
    logic [CNT_W-1:0]    new_cnt;

    always_comb begin
        hz_rs       = id_use_rs && id_rs != '0 &&
                      (id_is_branch ? cnt[id_rs] != '0 : ld[id_rs] && cnt[id_rs] > USE_TH);
        hz_rt       = id_use_rt && id_rt != '0 &&
                      (id_is_branch ? cnt[id_rt] != '0 : ld[id_rt] && cnt[id_rt] > USE_TH);
        stall       = id_valid && !id_flush && (hz_rs || hz_rt);
        pc_write    = !stall;
        if_id_write = !stall;
        issue       = id_valid && !id_flush && !stall && id_reg_write && id_dest != '0;
        new_cnt     = id_is_load ? LD_L : ALU_L;
    end

    // Register 0 is never written after reset, so it can never hazard.
    // The newest writer overwrites any countdown still running on its register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '{default: '0};
            ld  <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && id_dest == REG_W'(r)) begin
                    cnt[r] <= new_cnt;
                    ld[r]  <= id_is_load && new_cnt != '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                    ld[r]  <= ld[r] && cnt[r] != CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            busy_vec[r] = cnt[r] != '0;
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif
endmodule
